instr_queue: RTL and testbench
==============================

// Module: instr_queue
// PURPOSE
//  Dual-issue instruction FIFO between fetch and decode. Fetch pushes up to two words/cycle, decode pops up to two.
//  Predecodes each entering word to mark the instruction after any branch/jump as in_delay_slot.
//  Absorbs fetch/decode rate mismatch and is cleared by a pipeline flush (branch redirect, exception, ERET).
// PARAMETERS
//  DEPTH  8  entry count; power of 2, >= 4
// PORTS
//  clk          in   1   clock, all state updates on posedge
//  reset        in   1   synchronous, active-high
//  flush        in   1   drop all entries and this cycle's push/pop
//  in_valid     in   2   push mask; legal values 00, 01, 11
//  in_instr0/1  in   32  instruction words, slot 0 older
//  in_pc0/1     in   32  PCs of the words
//  in_adel0/1   in   1   fetch address-error flag per word
//  in_ready     out  1   free slots >= 2
//  out_valid    out  2   [0]: count>=1; [1]: count>=2
//  out_instr0/1 out  32  head / head+1 instruction, 0 when its valid bit is 0
//  out_pc0/1    out  32  PCs, 0 when invalid
//  out_delay0/1 out  1   in_delay_slot flags, 0 when invalid
//  out_adel0/1  out  1   address-error flags, 0 when invalid
//  out_pop      in   2   pop mask; legal values 00, 01, 11
//  count        out  $clog2(DEPTH)+1  occupancy
// BEHAVIOUR
//  - Storage: DEPTH-entry register array {instr, pc, adel, delay}.
//  - Pointers: head/tail, $clog2(DEPTH) bits, wrap modulo DEPTH. count is a separate register.
//  - Reset / flush (flush has priority over push and pop):
//    head = tail = count = 0, last_br = 0, push and pop ignored.
//    After reset: out_valid=00, every out_* data = 0, in_ready=1.
//  - in_ready is combinational from registered count only (DEPTH-count >= 2). It does not look at the same-cycle pop.
//  - Push when in_ready=1:
//    in_valid=01 writes slot 0 at tail; 11 writes slots 0,1 at tail, tail+1.
//    tail += popcount(in_valid).
//    Pushing with in_ready=0 is an upstream protocol error; the push is dropped and a bench assertion fires.
//  - Pop:
//    out_pop bits must be subset of out_valid; illegal pops are ignored and asserted.
//    head += popcount(out_pop).
//  - Simultaneous push and pop in one cycle:
//    count_next = count + pushed - popped. Both sides use pre-update pointers.
//  - Latency: a word pushed in cycle N is visible on out_* in cycle N+1 (no fall-through).
//    Output is a combinational read of entries head and head+1 (mod DEPTH).
//  - Predecode: is_br = op in {000100 BEQ, 000101 BNE, 000001 REGIMM, 000111 BGTZ, 000110 BLEZ, 000010 J, 000011 JAL},
//    or (op==000000 and funct in {001000 JR, 001001 JALR}). op = instr[31:26], funct = instr[5:0].
//    A word with adel=1 has is_br forced to 0.
//  - Delay flag:
//    entry written from slot 0 gets delay = last_br.
//    entry written from slot 1 gets delay = is_br(slot 0).
//    last_br <= is_br of youngest word pushed this cycle; it holds when nothing is pushed.
//    The flag therefore crosses cycle boundaries.
//  - Branch and its delay slot may be popped in different cycles. Pairing is decode's responsibility.
// TESTING
//  1. Assert reset 2 cycles -> out_valid=00, count=0, in_ready=1, all out data 0.
//  2. Push {0xBFC00000 addu, 0xBFC00004 beq}, then next cycle push 0xBFC00008 alone
//     -> pop order 000,004,008; delay flags 0,0,1.
//  3. Push JR (0x03E00008) alone, idle 3 cycles, then push 0x00000000
//     -> nop entry has out_delay=1 (last_br held across idle cycles).
//  4. DEPTH=8: push pairs until in_ready=0 -> count=7 or 8, in_ready low.
//     Then stream 40 words with push2/pop2 every cycle at count=4 -> count stays 4, pointers wrap, PC order preserved.
//  5. count=5 with a BNE youngest; assert flush together with in_valid=11 and out_pop=11
//     -> next cycle count=0, out_valid=00. Following push gets delay=0.
//  6. Push word with in_adel0=1 whose instr decodes as BEQ, then a normal word
//     -> out_adel0=1 on first; second has delay=0.

Source files
------------

// File: rtl/instr_queue.sv
// -----------------------------------------------------------------------------
// instr_queue
//   Dual-issue instruction FIFO sitting between fetch and decode. Fetch may
//   push up to two words per cycle and decode may pop up to two. Each word is
//   predecoded as it enters so that the word following any branch/jump is
//   tagged as a delay-slot instruction, even when the pair straddles cycles.
//   A flush drops every entry together with that cycle's push and pop.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   flush                   clear all entries, ignore this cycle's push/pop
//   in_valid[1:0]           push mask (00, 01, 11); slot 0 is older
//   in_instr0/1, in_pc0/1   pushed instruction words and their PCs
//   in_adel0/1              fetch address-error flag per pushed word
//   in_ready                at least two free entries
//   out_valid[1:0]          [0]: one or more entries, [1]: two or more
//   out_instr0/1, out_pc0/1 head / head+1 entry, zero when not valid
//   out_delay0/1            delay-slot flag of head / head+1, zero when not valid
//   out_adel0/1             address-error flag of head / head+1, zero when not valid
//   out_pop[1:0]            pop mask (00, 01, 11)
//   count                   occupancy
//
// Handshake: a push is taken on a posedge when in_ready=1 and in_valid is 01
// or 11; in_ready depends only on the registered count, so a pop in the same
// cycle never frees room for that cycle's push. A pop is taken when out_pop is
// 01 with out_valid[0]=1 or 11 with out_valid[1]=1; any other nonzero mask is
// ignored. Pushed words become visible on out_* the cycle after the push.
// -----------------------------------------------------------------------------
module instr_queue #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [1:0]                 in_valid,
    input  logic [31:0]                in_instr0,
    input  logic [31:0]                in_instr1,
    input  logic [31:0]                in_pc0,
    input  logic [31:0]                in_pc1,
    input  logic                       in_adel0,
    input  logic                       in_adel1,
    output logic                       in_ready,
    output logic [1:0]                 out_valid,
    output logic [31:0]                out_instr0,
    output logic [31:0]                out_instr1,
    output logic [31:0]                out_pc0,
    output logic [31:0]                out_pc1,
    output logic                       out_delay0,
    output logic                       out_delay1,
    output logic                       out_adel0,
    output logic                       out_adel1,
    input  logic [1:0]                 out_pop,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Entry storage. Contents are only observed through valid-gated outputs,
    // so the array needs no reset.
    logic [31:0]   r_instr [DEPTH];
    logic [31:0]   r_pc    [DEPTH];
    logic          r_adel  [DEPTH];
    logic          r_delay [DEPTH];

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    // Branch status of the youngest word pushed so far; carries the
    // delay-slot marking across cycle boundaries and idle cycles.
    logic          r_last_br;

    logic [CW-1:0] w_free;
    logic [CW-1:0] w_push_n;
    logic [CW-1:0] w_pop_n;
    logic [AW-1:0] w_tail1;
    logic [AW-1:0] w_head1;
    logic          w_br0;
    logic          w_br1;

    // Branch/jump predecode on opcode and, for SPECIAL, the function field.
    function automatic logic is_branch(input logic [5:0] op, input logic [5:0] funct);
        logic br;
        br = 1'b0;
        case (op)
            6'b000100, 6'b000101, 6'b000001, 6'b000111,
            6'b000110, 6'b000010, 6'b000011: br = 1'b1;
            6'b000000: br = (funct == 6'b001000) || (funct == 6'b001001);
            default:   br = 1'b0;
        endcase
        return br;
    endfunction

    // A word that faulted on fetch is never treated as a branch.
    assign w_br0 = !in_adel0 && is_branch(in_instr0[31:26], in_instr0[5:0]);
    assign w_br1 = !in_adel1 && is_branch(in_instr1[31:26], in_instr1[5:0]);

    assign w_free   = CW'(DEPTH) - r_count;
    assign in_ready = (w_free >= CW'(2));

    always_comb begin
        w_push_n = '0;
        if (in_ready) begin
            if (in_valid == 2'b01)      w_push_n = CW'(1);
            else if (in_valid == 2'b11) w_push_n = CW'(2);
        end
    end

    always_comb begin
        w_pop_n = '0;
        if (out_pop == 2'b01 && r_count >= CW'(1))      w_pop_n = CW'(1);
        else if (out_pop == 2'b11 && r_count >= CW'(2)) w_pop_n = CW'(2);
    end

    // Pointers are AW bits wide, so +1 wraps modulo DEPTH.
    assign w_tail1 = r_tail + AW'(1);
    assign w_head1 = r_head + AW'(1);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_last_br <= 1'b0;
        end else begin
            r_head  <= r_head + AW'(w_pop_n);
            r_tail  <= r_tail + AW'(w_push_n);
            r_count <= r_count + w_push_n - w_pop_n;
            if (w_push_n == CW'(2))      r_last_br <= w_br1;
            else if (w_push_n == CW'(1)) r_last_br <= w_br0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush && w_push_n != '0) begin
            r_instr[r_tail] <= in_instr0;
            r_pc[r_tail]    <= in_pc0;
            r_adel[r_tail]  <= in_adel0;
            r_delay[r_tail] <= r_last_br;
            if (w_push_n == CW'(2)) begin
                r_instr[w_tail1] <= in_instr1;
                r_pc[w_tail1]    <= in_pc1;
                r_adel[w_tail1]  <= in_adel1;
                r_delay[w_tail1] <= w_br0;
            end
        end
    end

    assign count        = r_count;
    assign out_valid[0] = (r_count >= CW'(1));
    assign out_valid[1] = (r_count >= CW'(2));

    assign out_instr0 = out_valid[0] ? r_instr[r_head]  : 32'd0;
    assign out_pc0    = out_valid[0] ? r_pc[r_head]     : 32'd0;
    assign out_delay0 = out_valid[0] ? r_delay[r_head]  : 1'b0;
    assign out_adel0  = out_valid[0] ? r_adel[r_head]   : 1'b0;
    assign out_instr1 = out_valid[1] ? r_instr[w_head1] : 32'd0;
    assign out_pc1    = out_valid[1] ? r_pc[w_head1]    : 32'd0;
    assign out_delay1 = out_valid[1] ? r_delay[w_head1] : 1'b0;
    assign out_adel1  = out_valid[1] ? r_adel[w_head1]  : 1'b0;

endmodule

// File: tb/tb_instr_queue.sv
module tb_instr_queue;

    localparam int DEPTH = 8;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [1:0]  in_valid;
    logic [31:0] in_instr0, in_instr1, in_pc0, in_pc1;
    logic        in_adel0, in_adel1;
    logic        in_ready;
    logic [1:0]  out_valid;
    logic [31:0] out_instr0, out_instr1, out_pc0, out_pc1;
    logic        out_delay0, out_delay1, out_adel0, out_adel1;
    logic [1:0]  out_pop;
    logic [3:0]  count;

    always #5 clk = ~clk;

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid),
        .in_instr0(in_instr0), .in_instr1(in_instr1),
        .in_pc0(in_pc0), .in_pc1(in_pc1),
        .in_adel0(in_adel0), .in_adel1(in_adel1),
        .in_ready(in_ready), .out_valid(out_valid),
        .out_instr0(out_instr0), .out_instr1(out_instr1),
        .out_pc0(out_pc0), .out_pc1(out_pc1),
        .out_delay0(out_delay0), .out_delay1(out_delay1),
        .out_adel0(out_adel0), .out_adel1(out_adel1),
        .out_pop(out_pop), .count(count)
    );

    // ---------------- scoreboard ----------------
    // Entry layout: {instr[65:34], pc[33:2], delay[1], adel[0]}
    logic [65:0] exp_q[$];
    logic        m_last_br;
    int          n_assert = 0;
    int          n_fail   = 0;

    function automatic logic m_is_br(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] fn;
        op = w[31:26];
        fn = w[5:0];
        if (op == 6'h04 || op == 6'h05 || op == 6'h01 || op == 6'h07 ||
            op == 6'h06 || op == 6'h02 || op == 6'h03) return 1'b1;
        if (op == 6'h00 && (fn == 6'h08 || fn == 6'h09)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the scoreboard state.
    task automatic check_outputs(input string tag);
        logic [65:0] e0, e1;
        int          n;
        n  = exp_q.size();
        e0 = (n > 0) ? exp_q[0] : 66'd0;
        e1 = (n > 1) ? exp_q[1] : 66'd0;
        chk({tag, ".count"},     32'(count),     32'(n));
        chk({tag, ".in_ready"},  32'(in_ready),  32'((DEPTH - n) >= 2));
        chk({tag, ".out_valid"}, 32'(out_valid), {30'd0, (n > 1), (n > 0)});
        chk({tag, ".instr0"},    out_instr0,     e0[65:34]);
        chk({tag, ".pc0"},       out_pc0,        e0[33:2]);
        chk({tag, ".delay0"},    32'(out_delay0), 32'(e0[1]));
        chk({tag, ".adel0"},     32'(out_adel0),  32'(e0[0]));
        chk({tag, ".instr1"},    out_instr1,     e1[65:34]);
        chk({tag, ".pc1"},       out_pc1,        e1[33:2]);
        chk({tag, ".delay1"},    32'(out_delay1), 32'(e1[1]));
        chk({tag, ".adel1"},     32'(out_adel1),  32'(e1[0]));
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1: check current outputs, drive one cycle, update model.
    task automatic do_cycle(input string tag, input logic [1:0] v,
                            input logic [31:0] i0, input logic [31:0] p0, input logic a0,
                            input logic [31:0] i1, input logic [31:0] p1, input logic a1,
                            input logic [1:0] pop, input logic fl);
        int  pre_n;
        logic br0, br1;
        check_outputs(tag);
        in_valid  = v;
        in_instr0 = i0; in_pc0 = p0; in_adel0 = a0;
        in_instr1 = i1; in_pc1 = p1; in_adel1 = a1;
        out_pop   = pop;
        flush     = fl;
        @(posedge clk);
        #1;
        in_valid = 2'b00;
        out_pop  = 2'b00;
        flush    = 1'b0;
        pre_n    = exp_q.size();
        if (fl) begin
            exp_q.delete();
            m_last_br = 1'b0;
        end else begin
            if (pop == 2'b01 && pre_n >= 1) void'(exp_q.pop_front());
            else if (pop == 2'b11 && pre_n >= 2) begin
                void'(exp_q.pop_front());
                void'(exp_q.pop_front());
            end
            if ((v == 2'b01 || v == 2'b11) && (DEPTH - pre_n) >= 2) begin
                br0 = !a0 && m_is_br(i0);
                br1 = !a1 && m_is_br(i1);
                exp_q.push_back({i0, p0, m_last_br, a0});
                if (v == 2'b11) begin
                    exp_q.push_back({i1, p1, br0, a1});
                    m_last_br = br1;
                end else begin
                    m_last_br = br0;
                end
            end
        end
    endtask

    task automatic push1(input string tag, input logic [31:0] i, input logic [31:0] p, input logic a);
        do_cycle(tag, 2'b01, i, p, a, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic push2(input string tag, input logic [31:0] i0, input logic [31:0] p0,
                         input logic [31:0] i1, input logic [31:0] p1);
        do_cycle(tag, 2'b11, i0, p0, 1'b0, i1, p1, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic pop(input string tag, input logic [1:0] m);
        do_cycle(tag, 2'b00, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, m, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    localparam logic [31:0] ADDU = 32'h0022_1821;
    localparam logic [31:0] BEQ  = 32'h1022_0003;
    localparam logic [31:0] BNE  = 32'h1422_0005;
    localparam logic [31:0] JR   = 32'h03E0_0008;
    localparam logic [31:0] NOP  = 32'h0000_0000;

    initial begin
        logic [31:0] pc;
        reset = 1'b1; flush = 1'b0; in_valid = 2'b00; out_pop = 2'b00;
        in_instr0 = '0; in_instr1 = '0; in_pc0 = '0; in_pc1 = '0;
        in_adel0 = 1'b0; in_adel1 = 1'b0;
        m_last_br = 1'b0;

        // 1: reset for two cycles
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_outputs("t1_reset");

        // 2: beq in slot 1 marks the next-cycle word as delay slot
        push2("t2_push2", ADDU, 32'hBFC0_0000, BEQ, 32'hBFC0_0004);
        push1("t2_push1", NOP, 32'hBFC0_0008, 1'b0);
        chk("t2_head_delay", 32'(out_delay0), 32'd0);
        pop("t2_pop2", 2'b11);
        chk("t2_slot_delay", 32'(out_delay0), 32'd1);
        pop("t2_pop1", 2'b01);

        // 3: jr alone, idle, then nop still gets the delay flag
        push1("t3_jr", JR, 32'hBFC0_0010, 1'b0);
        pop("t3_idle0", 2'b00);
        pop("t3_idle1", 2'b00);
        pop("t3_idle2", 2'b00);
        push1("t3_nop", NOP, 32'hBFC0_0014, 1'b0);
        chk("t3_nop_delay", 32'(out_delay1), 32'd1);
        pop("t3_pop2", 2'b11);

        // 4: fill, dropped push, then steady-state streaming with wrap
        pc = 32'h8000_0000;
        for (int i = 0; i < 6 && in_ready; i++) begin
            push2("t4_fill", ADDU + 32'(i), pc, ADDU, pc + 32'd4);
            pc += 32'd8;
        end
        chk("t4_full_count", 32'(count), 32'd8);
        chk("t4_full_ready", 32'(in_ready), 32'd0);
        push2("t4_drop", BEQ, 32'hDEAD_0000, ADDU, 32'hDEAD_0004);
        pop("t4_drain_a", 2'b11);
        pop("t4_drain_b", 2'b11);
        for (int i = 0; i < 20; i++) begin
            logic [31:0] r0, r1;
            r0 = $urandom();
            r1 = ($urandom_range(0, 3) == 0) ? JR : $urandom();
            do_cycle("t4_stream", 2'b11, r0, pc, 1'b0, r1, pc + 32'd4, 1'b0, 2'b11, 1'b0);
            pc += 32'd8;
        end
        chk("t4_stream_count", 32'(count), 32'd4);
        pop("t4_end_a", 2'b11);
        pop("t4_end_b", 2'b11);

        // 5: flush with BNE youngest, concurrent push and pop dropped
        push2("t5_a", ADDU, 32'h0000_1000, ADDU, 32'h0000_1004);
        push2("t5_b", ADDU, 32'h0000_1008, ADDU, 32'h0000_100C);
        push1("t5_bne", BNE, 32'h0000_1010, 1'b0);
        chk("t5_count5", 32'(count), 32'd5);
        do_cycle("t5_flush", 2'b11, ADDU, 32'h0000_2000, 1'b0, ADDU, 32'h0000_2004, 1'b0, 2'b11, 1'b1);
        chk("t5_after_flush", 32'(count), 32'd0);
        push1("t5_post", NOP, 32'h0000_3000, 1'b0);
        chk("t5_post_delay", 32'(out_delay0), 32'd0);
        pop("t5_pop", 2'b01);

        // 6: faulting BEQ does not mark its successor
        push1("t6_adel", BEQ, 32'h0000_4000, 1'b1);
        push1("t6_next", ADDU, 32'h0000_4004, 1'b0);
        chk("t6_adel0", 32'(out_adel0), 32'd1);
        chk("t6_next_delay", 32'(out_delay1), 32'd0);
        pop("t6_pop", 2'b11);
        check_outputs("t6_empty");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
